id_exe_stage: RTL

Parametrised ID→EXE pipeline stage. It replaces the fixed hold-only ID/EXE latch with a two-entry elastic buffer that uses a valid/ready handshake, a working flush, and operand/immediate formation generalised to `DATA_W`. It sits between the decoder/register-file read stage and the ALU. The ALU sees `op1`/`op2`, the forwarded register values, PC, instruction word and memory/writeback controls, all registered.

---
 rtl/id_exe_stage.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/id_exe_stage.sv
// rtl/id_exe_stage.sv - two-entry elastic ID->EXE pipeline stage with ALU operand formation
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid / in_ready           upstream handshake from ID (in_ready = not FULL)
//   opn, pc, read_value1/2        instruction word, PC, register-file read data
//   mem_write, mem_read,
//   reg_write, reg_addr           memory/writeback controls from ID
//   flush                         discard all buffered entries and the current input
//   exe_ready / out_valid         downstream handshake to EXE
//   opn_out, pc_out,
//   read_value1/2_output          registered pass-through of the MAIN entry
//   op1, op2, mem_write_value     ALU operands and store data of the MAIN entry
//   *_out controls                gated by out_valid
//   issue_count                   instructions delivered to EXE, wrapping
module id_exe_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       opn,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] read_value1,
  input  logic [DATA_W-1:0] read_value2,
  input  logic              mem_write,
  input  logic              mem_read,
  input  logic              reg_write,
  input  logic [REG_AW-1:0] reg_addr,
  input  logic              flush,
  input  logic              exe_ready,
  output logic              out_valid,
  output logic [15:0]       opn_out,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] read_value1_output,
  output logic [DATA_W-1:0] read_value2_output,
  output logic [DATA_W-1:0] op1,
  output logic [DATA_W-1:0] op2,
  output logic [DATA_W-1:0] mem_write_value,
  output logic              mem_write_out,
  output logic              mem_read_out,
  output logic              reg_write_out,
  output logic [REG_AW-1:0] reg_addr_out,
  output logic [CNT_W-1:0]  issue_count
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_t;

  typedef struct packed {
    logic [15:0]       opn;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] rv1;
    logic [DATA_W-1:0] rv2;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic              mw;
    logic              mr;
    logic              rw;
    logic [REG_AW-1:0] ra;
  } entry_t;

  occ_t             state_q, state_d;
  entry_t           main_q, skid_q, new_e;
  logic [CNT_W-1:0] cnt_q;
  logic             accept, deliver;

  logic [DATA_W-1:0] sx8, sx5, sx4, shamt;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid && in_ready;
  assign deliver   = out_valid && exe_ready;

  assign sx8   = {{(DATA_W-8){opn[7]}}, opn[7:0]};
  assign sx5   = {{(DATA_W-5){opn[4]}}, opn[4:0]};
  assign sx4   = {{(DATA_W-4){opn[3]}}, opn[3:0]};
  // A zero shift field stands for a shift by 8.
  assign shamt = (opn[4:2] == 3'b000) ? DATA_W'(8) : DATA_W'(opn[4:2]);

  // Entry built from the current input; operands are resolved here so each
  // buffered entry carries its own op1/op2.
  always_comb begin
    new_e     = '0;
    new_e.opn = opn;
    new_e.pc  = pc;
    new_e.rv1 = read_value1;
    new_e.rv2 = read_value2;
    new_e.mw  = mem_write;
    new_e.mr  = mem_read;
    new_e.rw  = reg_write;
    new_e.ra  = reg_addr;
    case (opn[15:11])
      5'b01001, 5'b10010, 5'b11010: begin
        new_e.op1 = read_value1;
        new_e.op2 = sx8;
      end
      5'b01100: begin
        if (opn[10:8] == 3'b011) begin
          new_e.op1 = read_value1;
          new_e.op2 = sx8;
        end else if (opn[10:8] == 3'b100 && opn[4:0] == 5'b00000) begin
          new_e.op1 = read_value1;
        end
      end
      5'b01000: begin
        new_e.op1 = read_value1;
        new_e.op2 = sx4;
      end
      5'b10011, 5'b11011: begin
        new_e.op1 = read_value1;
        new_e.op2 = sx5;
      end
      5'b11100: begin
        new_e.op1 = read_value1;
        new_e.op2 = read_value2;
      end
      5'b11101: begin
        if (opn[4:0] == 5'b01100 || opn[4:0] == 5'b01101 ||
            opn[4:0] == 5'b01010 || opn[4:0] == 5'b00111) begin
          new_e.op1 = read_value1;
          new_e.op2 = read_value2;
        end else if (opn[7:0] == 8'b0100_0000) begin
          new_e.op1 = pc + DATA_W'(1);
        end
      end
      5'b01101: new_e.op1 = DATA_W'(opn[7:0]);
      5'b11110: begin
        if (opn[7:0] == 8'h00 || opn[4:0] == 5'b00001) new_e.op1 = read_value1;
      end
      5'b00110: begin
        if (opn[1:0] != 2'b01) begin
          new_e.op1 = read_value2;
          new_e.op2 = shamt;
        end
      end
      5'b01111: begin
        if (opn[4:0] == 5'b00000) new_e.op1 = read_value2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) state_d = ONE;
        ONE: begin
          if (accept && !deliver)      state_d = FULL;
          else if (!accept && deliver) state_d = EMPTY;
        end
        FULL:    if (deliver) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Entry storage and delivery counter. Flush leaves MAIN untouched so the
  // data outputs hold their last values; only the state goes EMPTY.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (deliver) cnt_q <= cnt_q + CNT_W'(1);
      if (!flush) begin
        case (state_q)
          EMPTY: if (accept) main_q <= new_e;
          ONE: begin
            if (accept && deliver) main_q <= new_e;
            else if (accept)       skid_q <= new_e;
          end
          FULL:    if (deliver) main_q <= skid_q;
          default: ;
        endcase
      end
    end
  end

  assign opn_out            = main_q.opn;
  assign pc_out             = main_q.pc;
  assign read_value1_output = main_q.rv1;
  assign read_value2_output = main_q.rv2;
  assign op1                = main_q.op1;
  assign op2                = main_q.op2;
  assign mem_write_value    = main_q.rv2;
  assign reg_addr_out       = main_q.ra;
  assign mem_write_out      = out_valid && main_q.mw;
  assign mem_read_out       = out_valid && main_q.mr;
  assign reg_write_out      = out_valid && main_q.rw;
  assign issue_count        = cnt_q;

endmodule
